pc_fetch: RTL and testbench
===========================

# pc_fetch

Fetch-stage front end: holds the program counter, drives the instruction-memory address, and captures each fetched instruction into the IF/ID pipeline register. It sits directly upstream of the PC+4 `adder`, which it instantiates for the sequential next-PC. It also accepts branch redirects and stalls from later stages, detects `HLT`, and counts delivered instructions.

## Interface
- `WORD`, 64 (from `definitions.vh`), address/PC width
- `INSTR`, 32, instruction width
- `RESET_PC`, 0, PC value loaded on reset
- `clk`  in  1  single clock; all state updates on the rising edge
- `reset`  in  1  synchronous, active-high; sampled on the `clk` rising edge
- `stall`  in  1  hold the PC and IF/ID contents this cycle
- `branch_taken`  in  1  redirect request from a later stage
- `branch_target`  in  WORD  redirect address; bits [1:0] are ignored and treated as 0
- `imem_addr`  out  WORD  equals the current `pc`; combinational from the PC register
- `imem_data`  in  INSTR  instruction at `imem_addr`; combinational read, valid in the same cycle
- `ifid_pc`  out  WORD  PC of the instruction held in IF/ID
- `ifid_instr`  out  INSTR  instruction held in IF/ID
- `ifid_valid`  out  1  IF/ID holds a real instruction
- `halted`  out  1  fetch is in the HALTED state
- `fetch_count`  out  32  number of instructions written into IF/ID with valid=1

## Operation
- States: RUN and HALTED. Reset enters RUN.
- Halt detection: `is_hlt` = (`imem_data` & 32'hFFE0001F) == 32'hD4400000.
- Next-PC sequential value = `adder`(Ain=`pc`, Bin=4). Arithmetic is mod 2^WORD, so 0xFFFF_FFFF_FFFF_FFFC wraps to 0.
- Priority at each rising edge, highest first:
  1. `reset`: `pc`=RESET_PC, `ifid_pc`=0, `ifid_instr`=0, `ifid_valid`=0, `fetch_count`=0, state=RUN.
  2. `branch_taken` (either state, stall ignored): `pc`={`branch_target`[WORD-1:2],2'b00}, `ifid_valid`=0, `ifid_pc`/`ifid_instr` unchanged, state=RUN. This squashes the wrong-path instruction being fetched and whatever IF/ID holds.
  3. `stall`: all registers hold, including `ifid_valid` and `fetch_count`.
  4. RUN with !`is_hlt`: `ifid_pc`=`pc`, `ifid_instr`=`imem_data`, `ifid_valid`=1, `pc`=`pc`+4, `fetch_count`+1.
  5. RUN with `is_hlt`: the HLT instruction is captured into IF/ID with valid=1 and counted. `pc` holds at the HLT address; state=HALTED.
  6. HALTED: `pc` holds, `ifid_valid`=0, IF/ID data holds, count holds.
- `halted` = (state==HALTED). Only `reset` or `branch_taken` leaves HALTED; a branch resolves an older instruction, so the HLT may have been wrong-path.
- `fetch_count` wraps from 0xFFFFFFFF to 0.
- Reset mid-operation discards everything, including a pending branch in the same cycle.

## Timing
- Reset values: `pc`=RESET_PC (so `imem_addr`=RESET_PC), `ifid_pc`=0, `ifid_instr`=0, `ifid_valid`=0, `halted`=0, `fetch_count`=0.
- Fetch-to-IF/ID latency: 1 cycle. The instruction at address A, fetched in cycle n, appears on the `ifid_*` outputs in cycle n+1.
- Throughput: 1 instruction per cycle when there is no stall or branch.
- Branch redirect: `branch_taken` sampled in cycle n gives `imem_addr`=target in cycle n+1 and `ifid_valid`=0 in cycle n+1. The first target instruction is valid in IF/ID in cycle n+2 (1 bubble).
- `stall` held for k cycles freezes the outputs for exactly k cycles; fetch resumes on the next edge with `stall`=0.
- `branch_taken` and `stall` are expected to be single-cycle-qualified; `branch_taken` held high re-redirects every cycle.

## Test plan
- Reset then 4 free-running cycles, imem returning NOPs (0xD503201F), RESET_PC=0 -> `imem_addr` sequence 0,4,8,12,16. `ifid_pc` reads 0,4,8,12 from cycle 1 on, `ifid_valid`=1 from cycle 1, `fetch_count`=4.
- `branch_taken`=1 with target 0x103 at pc=8 -> next `imem_addr`=0x100 and `ifid_valid`=0 for 1 cycle. The following cycle gives `ifid_pc`=0x100, valid=1.
- `stall` high for 3 cycles at pc=12 -> `imem_addr`, `ifid_*` and `fetch_count` are frozen for 3 cycles, then the sequence resumes 16, 20.
- `imem_data`=0xD4400000 at pc=0x20 -> `ifid_instr`=0xD4400000 valid; `halted`=1, `imem_addr` stays 0x20, and valid=0 afterwards. A later `branch_taken` to 0x40 clears `halted` and fetches from 0x40.
- Simultaneous `branch_taken`+`stall` (target 0x80), then `reset` asserted together with `branch_taken` -> the first case redirects to 0x80. The second gives `imem_addr`=RESET_PC with all outputs at their reset values.
- RESET_PC=0xFFFFFFFFFFFFFFFC, 2 cycles -> `imem_addr` goes 0xFFFFFFFFFFFFFFFC then 0x0.

Source files
------------

// File: rtl/pc_fetch.sv
// pc_fetch: fetch-stage front end. Holds the PC, addresses instruction
// memory, captures fetched instructions into IF/ID, handles branch
// redirects, stalls and HLT, and counts delivered instructions.

// Sequential next-PC adder (modular WORD-bit add).
module adder #(
  parameter int WORD = 64
) (
  input  logic [WORD-1:0] ain,
  input  logic [WORD-1:0] bin,
  output logic [WORD-1:0] sum
);
  assign sum = ain + bin;
endmodule

module pc_fetch #(
  parameter int              WORD     = 64,
  parameter int              INSTR    = 32,
  parameter logic [WORD-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             branch_taken,
  input  logic [WORD-1:0]  branch_target,
  output logic [WORD-1:0]  imem_addr,
  input  logic [INSTR-1:0] imem_data,
  output logic [WORD-1:0]  ifid_pc,
  output logic [INSTR-1:0] ifid_instr,
  output logic             ifid_valid,
  output logic             halted,
  output logic [31:0]      fetch_count
);

  localparam logic [0:0] RUN    = 1'b0;
  localparam logic [0:0] HALTED = 1'b1;

  logic [0:0]      state;
  logic [WORD-1:0] pc;
  logic [WORD-1:0] pc_seq;
  logic            is_hlt;

  adder #(.WORD(WORD)) u_pc_add (
    .ain (pc),
    .bin (WORD'(4)),
    .sum (pc_seq)
  );

  // HLT: opcode bits match with the immediate field masked out.
  assign is_hlt    = (imem_data & 32'hFFE0001F) == 32'hD4400000;
  assign imem_addr = pc;
  assign halted    = (state == HALTED);

  // PC, IF/ID and fetch state; reset > branch > stall > run/halted.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc          <= RESET_PC;
      ifid_pc     <= '0;
      ifid_instr  <= '0;
      ifid_valid  <= 1'b0;
      fetch_count <= '0;
      state       <= RUN;
    end else if (branch_taken) begin
      // Squash both the in-flight fetch and whatever IF/ID holds.
      pc         <= {branch_target[WORD-1:2], 2'b00};
      ifid_valid <= 1'b0;
      state      <= RUN;
    end else if (stall) begin
      // hold everything
    end else if (state == RUN) begin
      ifid_pc     <= pc;
      ifid_instr  <= imem_data;
      ifid_valid  <= 1'b1;
      fetch_count <= fetch_count + 32'd1;
      if (is_hlt) state <= HALTED;  // PC parks on the HLT address
      else        pc    <= pc_seq;
    end else begin
      ifid_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pc_fetch.sv
// Directed bench for pc_fetch: expected post-edge outputs are pushed to a
// scoreboard queue as each step is driven and popped after the edge.
module tb_pc_fetch;

  localparam logic [31:0] NOP = 32'hD503201F;
  localparam logic [31:0] HLT = 32'hD4400000;

  logic        clk = 1'b0;
  logic        reset, stall, branch_taken;
  logic [63:0] branch_target;
  logic [63:0] imem_addr, ifid_pc;
  logic [31:0] imem_data, ifid_instr, fetch_count;
  logic        ifid_valid, halted;
  logic [63:0] hlt_at;

  logic        reset2;
  logic [63:0] imem_addr2, ifid_pc2;
  logic [31:0] ifid_instr2, fetch_count2;
  logic        ifid_valid2, halted2;

  int n_total = 0;
  int n_pass  = 0;

  typedef struct {
    logic [63:0] addr;
    logic [63:0] ipc;
    logic [31:0] instr;
    logic        v;
    logic        h;
    logic [31:0] cnt;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  // Address-dependent instruction word; top byte 0xD5 never decodes as HLT.
  function automatic logic [31:0] ins(input logic [63:0] a);
    return NOP ^ {8'h00, a[17:2], 8'h00};
  endfunction

  assign imem_data = (imem_addr == hlt_at) ? HLT : ins(imem_addr);

  pc_fetch #(.WORD(64), .INSTR(32), .RESET_PC(64'h0)) dut (
    .clk(clk), .reset(reset), .stall(stall), .branch_taken(branch_taken),
    .branch_target(branch_target), .imem_addr(imem_addr), .imem_data(imem_data),
    .ifid_pc(ifid_pc), .ifid_instr(ifid_instr), .ifid_valid(ifid_valid),
    .halted(halted), .fetch_count(fetch_count)
  );

  pc_fetch #(.WORD(64), .INSTR(32), .RESET_PC(64'hFFFF_FFFF_FFFF_FFFC)) dut2 (
    .clk(clk), .reset(reset2), .stall(1'b0), .branch_taken(1'b0),
    .branch_target(64'h0), .imem_addr(imem_addr2), .imem_data(NOP),
    .ifid_pc(ifid_pc2), .ifid_instr(ifid_instr2), .ifid_valid(ifid_valid2),
    .halted(halted2), .fetch_count(fetch_count2)
  );

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    assert (act === exp) n_pass++;
    else $error("FAIL %s: got %h expected %h", tag, act, exp);
  endtask

  // Drive one cycle of inputs, queue the expected result, compare after the edge.
  task automatic step(input string tag, input logic rst, input logic br,
                      input logic [63:0] tgt, input logic stl,
                      input logic [63:0] e_addr, input logic [63:0] e_ipc,
                      input logic [31:0] e_instr, input logic e_v,
                      input logic e_h, input logic [31:0] e_cnt);
    exp_t e;
    reset = rst; branch_taken = br; branch_target = tgt; stall = stl;
    e.addr = e_addr; e.ipc = e_ipc; e.instr = e_instr;
    e.v = e_v; e.h = e_h; e.cnt = e_cnt;
    sb.push_back(e);
    @(posedge clk); #1;
    if (sb.size() == 0) begin
      n_total++;
      $error("FAIL %s: scoreboard empty", tag);
    end else begin
      e = sb.pop_front();
      chk({tag, ".addr"},  imem_addr,  e.addr);
      chk({tag, ".ipc"},   ifid_pc,    e.ipc);
      chk({tag, ".instr"}, 64'(ifid_instr), 64'(e.instr));
      chk({tag, ".valid"}, 64'(ifid_valid), 64'(e.v));
      chk({tag, ".halt"},  64'(halted),     64'(e.h));
      chk({tag, ".cnt"},   64'(fetch_count), 64'(e.cnt));
    end
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = '0;
    hlt_at = '1; reset2 = 1'b1;

    // Reset state, then free-running sequential fetch.
    step("rst",  1, 0, 0, 0, 64'h00, 64'h00, 32'h0,    0, 0, 0);
    step("run1", 0, 0, 0, 0, 64'h04, 64'h00, ins(0),   1, 0, 1);
    step("run2", 0, 0, 0, 0, 64'h08, 64'h04, ins(4),   1, 0, 2);
    step("run3", 0, 0, 0, 0, 64'h0C, 64'h08, ins(8),   1, 0, 3);
    step("run4", 0, 0, 0, 0, 64'h10, 64'h0C, ins(12),  1, 0, 4);

    // Branch at pc=8 to 0x103 (low bits dropped).
    step("rstb", 1, 0, 0, 0, 64'h00, 64'h00, 32'h0,    0, 0, 0);
    step("b1",   0, 0, 0, 0, 64'h04, 64'h00, ins(0),   1, 0, 1);
    step("b2",   0, 0, 0, 0, 64'h08, 64'h04, ins(4),   1, 0, 2);
    step("br",   0, 1, 64'h103, 0, 64'h100, 64'h04, ins(4), 0, 0, 2);
    step("bt1",  0, 0, 0, 0, 64'h104, 64'h100, ins(64'h100), 1, 0, 3);
    step("bt2",  0, 0, 0, 0, 64'h108, 64'h104, ins(64'h104), 1, 0, 4);

    // Stall three cycles at pc=12.
    step("rsts", 1, 0, 0, 0, 64'h00, 64'h00, 32'h0,    0, 0, 0);
    step("s1",   0, 0, 0, 0, 64'h04, 64'h00, ins(0),   1, 0, 1);
    step("s2",   0, 0, 0, 0, 64'h08, 64'h04, ins(4),   1, 0, 2);
    step("s3",   0, 0, 0, 0, 64'h0C, 64'h08, ins(8),   1, 0, 3);
    for (int i = 0; i < 3; i++)
      step("stl", 0, 0, 0, 1, 64'h0C, 64'h08, ins(8),  1, 0, 3);
    step("res1", 0, 0, 0, 0, 64'h10, 64'h0C, ins(12),  1, 0, 4);
    step("res2", 0, 0, 0, 0, 64'h14, 64'h10, ins(16),  1, 0, 5);

    // HLT at 0x20, then a branch to 0x40 leaves HALTED.
    hlt_at = 64'h20;
    step("h1",   0, 0, 0, 0, 64'h18, 64'h14, ins(20),  1, 0, 6);
    step("h2",   0, 0, 0, 0, 64'h1C, 64'h18, ins(24),  1, 0, 7);
    step("h3",   0, 0, 0, 0, 64'h20, 64'h1C, ins(28),  1, 0, 8);
    step("hlt",  0, 0, 0, 0, 64'h20, 64'h20, HLT,      1, 1, 9);
    step("hd1",  0, 0, 0, 0, 64'h20, 64'h20, HLT,      0, 1, 9);
    step("hd2",  0, 0, 0, 0, 64'h20, 64'h20, HLT,      0, 1, 9);
    step("hbr",  0, 1, 64'h40, 0, 64'h40, 64'h20, HLT, 0, 0, 9);
    hlt_at = '1;
    step("hb1",  0, 0, 0, 0, 64'h44, 64'h40, ins(64'h40), 1, 0, 10);

    // Branch wins over stall; reset wins over branch.
    step("brst", 0, 1, 64'h80, 1, 64'h80, 64'h40, ins(64'h40), 0, 0, 10);
    step("bs1",  0, 0, 0, 0, 64'h84, 64'h80, ins(64'h80), 1, 0, 11);
    step("rsbr", 1, 1, 64'h80, 0, 64'h00, 64'h00, 32'h0, 0, 0, 0);

    // Reset PC at the top of the address space wraps to 0.
    reset = 1'b0; reset2 = 1'b1;
    @(posedge clk); #1;
    chk("w.addr0",  imem_addr2, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("w.valid0", 64'(ifid_valid2), 64'h0);
    reset2 = 1'b0;
    @(posedge clk); #1;
    chk("w.addr1",  imem_addr2, 64'h0);
    chk("w.ipc1",   ifid_pc2,   64'hFFFF_FFFF_FFFF_FFFC);
    chk("w.cnt1",   64'(fetch_count2), 64'h1);
    @(posedge clk); #1;
    chk("w.addr2",  imem_addr2, 64'h4);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
